// File: rtl/ts_ser_rx.sv
// Serial TS receiver: deserializes MSB-first bits into bytes, delineates
// packets on the sync flag, checks sync byte and length, and reports lock.
module ts_ser_rx #(
  parameter int         PKT_LEN   = 188,
  parameter logic [7:0] SYNC_BYTE = 8'h47,
  parameter int         LOCK_PKTS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ts_ser_data_i,
  input  logic       ts_ser_sync_i,
  input  logic       ts_ser_valid_i,
  output logic [7:0] ts_par_data_o,
  output logic       ts_par_sync_o,
  output logic       ts_par_valid_o,
  output logic       sync_err_o,
  output logic       len_err_o,
  output logic       locked_o
);

  localparam int              BCW       = $clog2(PKT_LEN);
  localparam logic [BCW-1:0]  LAST_BYTE = BCW'(PKT_LEN - 1);
  localparam logic [3:0]      LOCK_CNT  = 4'(LOCK_PKTS);

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [2:0]     bit_cnt, bit_cnt_nxt;
  logic [BCW-1:0] byte_cnt, byte_cnt_nxt;
  logic [7:0]     shreg, shreg_nxt;
  logic [3:0]     good_cnt, good_cnt_nxt;

  logic [7:0]     data_p0;
  logic           vld_p0, sync_p0, sync_err_p0, len_err_p0;
  logic           byte_done, first_ok;

  assign data_p0   = {shreg[6:0], ts_ser_data_i};
  assign first_ok  = (data_p0 == SYNC_BYTE);
  assign byte_done = ts_ser_valid_i && !ts_ser_sync_i && (state == RECV) && (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= HUNT;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
      shreg          <= '0;
      good_cnt       <= '0;
      ts_par_data_o  <= '0;
      ts_par_sync_o  <= 1'b0;
      ts_par_valid_o <= 1'b0;
      sync_err_o     <= 1'b0;
      len_err_o      <= 1'b0;
      locked_o       <= 1'b0;
    end else begin
      state          <= state_nxt;
      bit_cnt        <= bit_cnt_nxt;
      byte_cnt       <= byte_cnt_nxt;
      shreg          <= shreg_nxt;
      good_cnt       <= good_cnt_nxt;
      // p0 -> p1: byte strobe and error pulses appear the cycle after the edge
      if (vld_p0) ts_par_data_o <= data_p0;
      ts_par_sync_o  <= sync_p0;
      ts_par_valid_o <= vld_p0;
      sync_err_o     <= sync_err_p0;
      len_err_o      <= len_err_p0;
      locked_o       <= (good_cnt_nxt == LOCK_CNT);
    end
  end

  always_comb begin
    state_nxt = state;
    if (ts_ser_valid_i) begin
      if (ts_ser_sync_i) begin
        state_nxt = RECV;
      end else if (byte_done) begin
        if (byte_cnt == '0) begin
          if (!first_ok) state_nxt = HUNT;
        end else if (byte_cnt == LAST_BYTE) begin
          state_nxt = HUNT;
        end
      end
    end
  end

  always_comb begin
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    shreg_nxt    = shreg;
    good_cnt_nxt = good_cnt;
    vld_p0       = 1'b0;
    sync_p0      = 1'b0;
    sync_err_p0  = 1'b0;
    len_err_p0   = 1'b0;
    if (ts_ser_valid_i) begin
      if (ts_ser_sync_i) begin
        // A sync bit always opens byte 0; inside a packet it also aborts it.
        if (state == RECV) begin
          len_err_p0   = 1'b1;
          good_cnt_nxt = '0;
        end
        shreg_nxt    = {7'b0, ts_ser_data_i};
        bit_cnt_nxt  = 3'd1;
        byte_cnt_nxt = '0;
      end else if (state == RECV) begin
        shreg_nxt   = data_p0;
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (byte_cnt == '0) begin
            if (first_ok) begin
              vld_p0       = 1'b1;
              sync_p0      = 1'b1;
              byte_cnt_nxt = BCW'(1);
            end else begin
              sync_err_p0  = 1'b1;
              good_cnt_nxt = '0;
            end
          end else begin
            vld_p0 = 1'b1;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt_nxt = '0;
              if (good_cnt < LOCK_CNT) good_cnt_nxt = good_cnt + 4'd1;
            end else begin
              byte_cnt_nxt = byte_cnt + BCW'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ts_ser_rx.sv
// Directed bench for ts_ser_rx: packet streams, gaps, sync/length errors,
// pre-sync noise and mid-packet reset.
module tb_ts_ser_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ts_ser_data_i = 1'b0;
  logic       ts_ser_sync_i = 1'b0;
  logic       ts_ser_valid_i = 1'b0;
  logic [7:0] ts_par_data_o;
  logic       ts_par_sync_o;
  logic       ts_par_valid_o;
  logic       sync_err_o;
  logic       len_err_o;
  logic       locked_o;

  ts_ser_rx #(.PKT_LEN(188), .SYNC_BYTE(8'h47), .LOCK_PKTS(3)) dut (
    .clk(clk), .rst(rst),
    .ts_ser_data_i(ts_ser_data_i), .ts_ser_sync_i(ts_ser_sync_i),
    .ts_ser_valid_i(ts_ser_valid_i),
    .ts_par_data_o(ts_par_data_o), .ts_par_sync_o(ts_par_sync_o),
    .ts_par_valid_o(ts_par_valid_o), .sync_err_o(sync_err_o),
    .len_err_o(len_err_o), .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Monitor state: every strobe is logged as {sync, data, edge index}.
  logic [31:0] cyc = '0;
  logic [40:0] rx_q[$];
  logic [40:0] exp_q[$];
  int          serr_n = 0, lerr_n = 0, bad_sync_n = 0, rise_n = 0, fall_n = 0;
  logic [31:0] serr_cyc = '0, lerr_cyc = '0, rise_cyc = '0, fall_cyc = '0;
  logic        prev_lock = 1'b0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  always @(negedge clk) begin
    if (ts_par_valid_o === 1'b1) rx_q.push_back({ts_par_sync_o, ts_par_data_o, cyc});
    if (ts_par_sync_o === 1'b1 && ts_par_valid_o !== 1'b1) bad_sync_n++;
    if (sync_err_o === 1'b1) begin serr_n++; serr_cyc = cyc; end
    if (len_err_o === 1'b1) begin lerr_n++; lerr_cyc = cyc; end
    if (locked_o === 1'b1 && prev_lock === 1'b0) begin rise_n++; rise_cyc = cyc; end
    if (locked_o === 1'b0 && prev_lock === 1'b1) begin fall_n++; fall_cyc = cyc; end
    prev_lock = (locked_o === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Driver state
  bit          gap_mode = 1'b0;
  int          gap_ctr = 0;
  logic [31:0] last_cyc = '0, start_cyc = '0, pkt_end = '0;

  task automatic send_bit(input logic s, input logic d);
    @(negedge clk);
    if (gap_mode) begin
      if (gap_ctr == 3) begin
        gap_ctr = 0;
        repeat (5) begin
          ts_ser_valid_i = 1'b0; ts_ser_sync_i = 1'b1; ts_ser_data_i = 1'($urandom);
          @(negedge clk);
        end
      end
      gap_ctr++;
    end
    ts_ser_valid_i = 1'b1; ts_ser_sync_i = s; ts_ser_data_i = d;
    last_cyc = cyc + 32'd1;
    if (s) start_cyc = last_cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic first, input bit expect_strobe);
    for (int i = 7; i >= 0; i--) send_bit(first && (i == 7), b[i]);
    if (expect_strobe) exp_q.push_back({first, b, last_cyc});
  endtask

  task automatic send_packet();
    send_byte(8'h47, 1'b1, 1'b1);
    for (int j = 1; j < 188; j++) send_byte(8'(j - 1), 1'b0, 1'b1);
    pkt_end = last_cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ts_ser_valid_i = 1'b0; ts_ser_sync_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ts_ser_valid_i = 1'b1; ts_ser_sync_i = 1'b1; ts_ser_data_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; ts_ser_valid_i = 1'b0; ts_ser_sync_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (ts_par_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", ts_par_data_o); end
    n_chk++; if (ts_par_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ts_par_valid_o); end
    n_chk++; if (ts_par_sync_o !== 1'b0) begin n_fail++; $display("FAIL reset_sync got %b want 0", ts_par_sync_o); end
    n_chk++; if ({sync_err_o, len_err_o, locked_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {sync_err_o, len_err_o, locked_o}); end
  endtask

  task automatic test_stream(input bit gaps);
    int base, serr0, lerr0, bs0, rise0;
    do_reset();
    exp_q.delete(); base = rx_q.size();
    serr0 = serr_n; lerr0 = lerr_n; bs0 = bad_sync_n; rise0 = rise_n;
    gap_mode = gaps; gap_ctr = 0;
    repeat (3) send_packet();
    gap_mode = 1'b0;
    idle(3);
    n_chk++; if (rx_q.size() - base != 564) begin n_fail++; $display("FAIL stream%0d_count got %0d want 564", gaps, rx_q.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++) begin
      n_chk++;
      if (rx_q[base + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stream%0d_byte[%0d] got sync=%b data=%h cyc=%0d want sync=%b data=%h cyc=%0d", gaps, i,
                 rx_q[base + i][40], rx_q[base + i][39:32], rx_q[base + i][31:0], exp_q[i][40], exp_q[i][39:32], exp_q[i][31:0]);
      end
    end
    n_chk++; if (serr_n - serr0 != 0 || lerr_n - lerr0 != 0) begin n_fail++; $display("FAIL stream%0d_errs got serr=%0d lerr=%0d want 0 0", gaps, serr_n - serr0, lerr_n - lerr0); end
    n_chk++; if (bad_sync_n - bs0 != 0) begin n_fail++; $display("FAIL stream%0d_sync_without_valid got %0d want 0", gaps, bad_sync_n - bs0); end
    n_chk++; if (rise_n - rise0 != 1 || rise_cyc !== pkt_end) begin n_fail++; $display("FAIL stream%0d_lock_rise got n=%0d cyc=%0d want n=1 cyc=%0d", gaps, rise_n - rise0, rise_cyc, pkt_end); end
    n_chk++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL stream%0d_locked got %b want 1", gaps, locked_o); end
  endtask

  task automatic test_sync_err();
    int base, serr0, lerr0;
    logic [31:0] bad_cyc;
    exp_q.delete(); base = rx_q.size(); serr0 = serr_n; lerr0 = lerr_n;
    send_byte(8'h46, 1'b1, 1'b0);
    bad_cyc = last_cyc;
    for (int j = 0; j < 10; j++) send_byte(8'h47, 1'b0, 1'b0);
    idle(2);
    n_chk++; if (rx_q.size() != base) begin n_fail++; $display("FAIL serr_no_strobe got %0d want 0", rx_q.size() - base); end
    n_chk++; if (serr_n - serr0 != 1 || serr_cyc !== bad_cyc) begin n_fail++; $display("FAIL serr_pulse got n=%0d cyc=%0d want n=1 cyc=%0d", serr_n - serr0, serr_cyc, bad_cyc); end
    n_chk++; if (fall_cyc !== bad_cyc || locked_o !== 1'b0) begin n_fail++; $display("FAIL serr_lock_fall got cyc=%0d lock=%b want cyc=%0d lock=0", fall_cyc, locked_o, bad_cyc); end
    send_packet();
    idle(2);
    n_chk++; if (rx_q.size() - base != 188) begin n_fail++; $display("FAIL serr_next_count got %0d want 188", rx_q.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++) begin
      n_chk++;
      if (rx_q[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL serr_next_byte[%0d] got %h want %h", i, rx_q[base + i], exp_q[i]); end
    end
    n_chk++; if (serr_n - serr0 != 1 || lerr_n != lerr0) begin n_fail++; $display("FAIL serr_extra_errs got serr=%0d lerr=%0d want 1 0", serr_n - serr0, lerr_n - lerr0); end
  endtask

  task automatic test_len_err();
    int base, serr0, lerr0;
    do_reset();
    repeat (3) send_packet();
    idle(2);
    n_chk++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL lerr_prelock got %b want 1", locked_o); end
    exp_q.delete(); base = rx_q.size(); serr0 = serr_n; lerr0 = lerr_n;
    send_byte(8'h47, 1'b1, 1'b1);
    for (int j = 1; j < 100; j++) send_byte(8'(j - 1), 1'b0, 1'b1);
    repeat (3) send_bit(1'b0, 1'b1);
    send_packet();
    idle(2);
    n_chk++; if (rx_q.size() - base != 288) begin n_fail++; $display("FAIL lerr_count got %0d want 288", rx_q.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++) begin
      n_chk++;
      if (rx_q[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL lerr_byte[%0d] got %h want %h", i, rx_q[base + i], exp_q[i]); end
    end
    n_chk++; if (lerr_n - lerr0 != 1 || lerr_cyc !== start_cyc) begin n_fail++; $display("FAIL lerr_pulse got n=%0d cyc=%0d want n=1 cyc=%0d", lerr_n - lerr0, lerr_cyc, start_cyc); end
    n_chk++; if (fall_cyc !== start_cyc || locked_o !== 1'b0) begin n_fail++; $display("FAIL lerr_lock got fall=%0d lock=%b want fall=%0d lock=0", fall_cyc, locked_o, start_cyc); end
    n_chk++; if (serr_n != serr0) begin n_fail++; $display("FAIL lerr_serr got %0d want 0", serr_n - serr0); end
  endtask

  task automatic test_hunt_noise();
    int base, serr0, lerr0;
    do_reset();
    exp_q.delete(); base = rx_q.size(); serr0 = serr_n; lerr0 = lerr_n;
    repeat (37) send_bit(1'b0, 1'($urandom));
    idle(2);
    n_chk++; if (rx_q.size() != base || serr_n != serr0 || lerr_n != lerr0) begin n_fail++; $display("FAIL noise_quiet got strobes=%0d serr=%0d lerr=%0d want 0 0 0", rx_q.size() - base, serr_n - serr0, lerr_n - lerr0); end
    send_packet();
    idle(2);
    n_chk++; if (rx_q.size() - base != 188) begin n_fail++; $display("FAIL noise_count got %0d want 188", rx_q.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++) begin
      n_chk++;
      if (rx_q[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL noise_byte[%0d] got %h want %h", i, rx_q[base + i], exp_q[i]); end
    end
    n_chk++; if (serr_n != serr0 || lerr_n != lerr0 || locked_o !== 1'b0) begin n_fail++; $display("FAIL noise_flags got serr=%0d lerr=%0d lock=%b want 0 0 0", serr_n - serr0, lerr_n - lerr0, locked_o); end
  endtask

  task automatic test_reset_mid();
    int base, mid, serr0, lerr0, rise0;
    do_reset();
    exp_q.delete(); base = rx_q.size(); serr0 = serr_n; lerr0 = lerr_n; rise0 = rise_n;
    repeat (2) send_packet();
    send_byte(8'h47, 1'b1, 1'b1);
    for (int j = 1; j < 50; j++) send_byte(8'(j - 1), 1'b0, 1'b1);
    repeat (4) send_bit(1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1; ts_ser_valid_i = 1'b1; ts_ser_sync_i = 1'b1; ts_ser_data_i = 1'b1;
    @(negedge clk);
    n_chk++; if (ts_par_data_o !== 8'h00 || ts_par_valid_o !== 1'b0 || ts_par_sync_o !== 1'b0) begin n_fail++; $display("FAIL midrst_par got data=%h valid=%b sync=%b want 00 0 0", ts_par_data_o, ts_par_valid_o, ts_par_sync_o); end
    n_chk++; if ({sync_err_o, len_err_o, locked_o} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags got %b want 000", {sync_err_o, len_err_o, locked_o}); end
    rst = 1'b0; ts_ser_valid_i = 1'b0; ts_ser_sync_i = 1'b0;
    mid = rx_q.size();
    repeat (4) send_bit(1'b0, 1'b0);
    for (int j = 51; j < 188; j++) send_byte(8'(j - 1), 1'b0, 1'b0);
    idle(2);
    n_chk++; if (rx_q.size() != mid || serr_n != serr0 || lerr_n != lerr0) begin n_fail++; $display("FAIL midrst_ignored got strobes=%0d serr=%0d lerr=%0d want 0 0 0", rx_q.size() - mid, serr_n - serr0, lerr_n - lerr0); end
    repeat (3) send_packet();
    idle(2);
    n_chk++; if (rx_q.size() - base != 2 * 188 + 50 + 3 * 188) begin n_fail++; $display("FAIL midrst_count got %0d want %0d", rx_q.size() - base, 5 * 188 + 50); end
    for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++) begin
      n_chk++;
      if (rx_q[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_byte[%0d] got %h want %h", i, rx_q[base + i], exp_q[i]); end
    end
    n_chk++; if (rise_n - rise0 != 1 || rise_cyc !== pkt_end) begin n_fail++; $display("FAIL midrst_lock got n=%0d cyc=%0d want n=1 cyc=%0d", rise_n - rise0, rise_cyc, pkt_end); end
    n_chk++; if (serr_n != serr0 || lerr_n != lerr0) begin n_fail++; $display("FAIL midrst_errs got serr=%0d lerr=%0d want 0 0", serr_n - serr0, lerr_n - lerr0); end
  endtask

  initial begin
    test_reset();
    test_stream(1'b0);
    test_stream(1'b1);
    test_sync_err();
    test_len_err();
    test_hunt_noise();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
